// File: rtl/test_reg_pkg.sv
// Shared sizing constants and lane-index helper for the nibble-lane register test block.
package test_reg_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = NIBBLE_W * NUM_LANES;

  // Lane i of the stage-2 word is sourced from lane rev_lane(i) of stage 1.
  function automatic int rev_lane(input int i);
    return NUM_LANES - 1 - i;
  endfunction

endpackage

// File: rtl/test_reg_lane.sv
// One NIBBLE_W-bit register with synchronous active-high reset.
module test_reg_lane
  import test_reg_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state selection: reset has priority over the data input.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = '0;
    end else begin
      q_d = d;
    end
  end

  // Lane storage register.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/test_reg_nibble.sv
// Two-stage nibble-lane register: stage 1 copies A, stage 2 holds the lane-reversed stage-1 word.
module test_reg_nibble
  import test_reg_pkg::*;
#(
  parameter int DATA_W    = test_reg_pkg::DATA_W,
  parameter int NIBBLE_W  = test_reg_pkg::NIBBLE_W,
  parameter int NUM_LANES = test_reg_pkg::NUM_LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] outData,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // Stage-1 next state: reset clears the word, otherwise A is captured.
  always_comb begin
    a_d = a_q;
    if (rst) begin
      a_d = '0;
    end else begin
      a_d = A;
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  // Stage 2: one lane register per nibble, fed from the mirrored stage-1 lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    test_reg_lane #(
      .WIDTH(NIBBLE_W)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .d  (a_q[NIBBLE_W*rev_lane(i) +: NIBBLE_W]),
      .q  (b_q[NIBBLE_W*i +: NIBBLE_W])
    );
  end

  assign outData = a_q;
  assign B       = b_q;

endmodule

// File: tb/tb_test_reg_nibble.sv
// Directed self-checking bench for test_reg_nibble.
module tb_test_reg_nibble;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] outData;
  logic [15:0] B;

  int total;
  int bad;

  test_reg_nibble dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .outData(outData),
    .B      (B)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A   = 16'hFFFF;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (outData !== 16'h0000) begin
        total++; bad++;
        $display("FAIL reset_out actual=%h required=%h", outData, 16'h0000);
      end else total++;
      if (B !== 16'h0000) begin
        total++; bad++;
        $display("FAIL reset_b actual=%h required=%h", B, 16'h0000);
      end else total++;
    end
  endtask

  task automatic test_all_ones();
    rst = 1'b0;
    A   = 16'hFFFF;
    tick();
    total++;
    if (outData !== 16'hFFFF) begin bad++; $display("FAIL ones_out actual=%h required=%h", outData, 16'hFFFF); end
    total++;
    if (B !== 16'h0000) begin bad++; $display("FAIL ones_b1 actual=%h required=%h", B, 16'h0000); end
    tick();
    total++;
    if (B !== 16'hFFFF) begin bad++; $display("FAIL ones_b2 actual=%h required=%h", B, 16'hFFFF); end
  endtask

  task automatic test_lane_reversal();
    A = 16'h1234;
    tick();
    total++;
    if (outData !== 16'h1234) begin bad++; $display("FAIL rev_out actual=%h required=%h", outData, 16'h1234); end
    tick();
    total++;
    if (B !== 16'h4321) begin bad++; $display("FAIL rev_b_1234 actual=%h required=%h", B, 16'h4321); end
    A = 16'hF000;
    tick();
    tick();
    total++;
    if (B !== 16'h000F) begin bad++; $display("FAIL rev_b_f000 actual=%h required=%h", B, 16'h000F); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [4];
    logic [15:0] exp_b [4];
    vec   = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    exp_b = '{16'h1000, 16'h0100, 16'h0010, 16'h0001};
    for (int n = 0; n < 4; n++) begin
      A = vec[n];
      tick();
      total++;
      if (outData !== vec[n]) begin bad++; $display("FAIL b2b_out%0d actual=%h required=%h", n, outData, vec[n]); end
      if (n > 0) begin
        total++;
        if (B !== exp_b[n-1]) begin bad++; $display("FAIL b2b_b%0d actual=%h required=%h", n - 1, B, exp_b[n-1]); end
      end
    end
    A = 16'h0000;
    tick();
    total++;
    if (B !== exp_b[3]) begin bad++; $display("FAIL b2b_b3 actual=%h required=%h", B, exp_b[3]); end
  endtask

  task automatic test_reset_midstream();
    A = 16'hABCD;
    tick();
    tick();
    total++;
    if (B !== 16'hDCBA) begin bad++; $display("FAIL mid_pre_b actual=%h required=%h", B, 16'hDCBA); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (outData !== 16'h0000) begin bad++; $display("FAIL mid_rst_out actual=%h required=%h", outData, 16'h0000); end
    total++;
    if (B !== 16'h0000) begin bad++; $display("FAIL mid_rst_b actual=%h required=%h", B, 16'h0000); end
    tick();
    total++;
    if (outData !== 16'hABCD) begin bad++; $display("FAIL mid_rel_out actual=%h required=%h", outData, 16'hABCD); end
    total++;
    if (B !== 16'h0000) begin bad++; $display("FAIL mid_rel_b1 actual=%h required=%h", B, 16'h0000); end
    tick();
    total++;
    if (B !== 16'hDCBA) begin bad++; $display("FAIL mid_rel_b2 actual=%h required=%h", B, 16'hDCBA); end
  endtask

  task automatic test_lane_isolation();
    logic [15:0] exp_v;
    for (int p = 0; p < 16; p++) begin
      A = 16'h0001 << p;
      exp_v = 16'h0001 << (4 * (3 - p / 4) + p % 4);
      tick();
      tick();
      total++;
      if (B !== exp_v) begin bad++; $display("FAIL iso_bit%0d actual=%h required=%h", p, B, exp_v); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    A     = 16'hFFFF;
    test_reset();
    test_all_ones();
    test_lane_reversal();
    test_back_to_back();
    test_reset_midstream();
    test_lane_isolation();
    chk("final_out", outData, 16'h8000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
